// File: rtl/cpu_mem_arb_pkg.sv
// Shared types for the CPU / host / accelerator memory arbiter.
package cpu_mem_arb_pkg;
  localparam int BURST_LEN = 16;

  typedef enum logic [2:0] {OWN_NONE, OWN_CPU, OWN_EX, OWN_ACCEL, OWN_BURST} owner_e;
  typedef enum logic {ST_IDLE, ST_BURST} state_e;
endpackage

// File: rtl/cpu_mem_rr2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module cpu_mem_rr2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic pri_b;

  assign gnt_a = en && req_a && (!req_b || !pri_b);
  assign gnt_b = en && req_b && (!req_a || pri_b);

  always_ff @(posedge clk) begin
    if (rst)                 pri_b <= 1'b0;
    else if (gnt_a || gnt_b) pri_b <= gnt_a;
  end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter: CPU first, host/accel round-robin, plus an
// accelerator line-read burst engine that yields beats to the CPU.
module cpu_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = cpu_mem_arb_pkg::BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req,
  input  logic                        cpu_wr,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic                        cpu_gnt,
  output logic                        cpu_rvalid,
  output logic [DATA_W-1:0]           cpu_rdata,
  input  logic                        ex_req,
  input  logic                        ex_wr,
  input  logic [ADDR_W-1:0]           ex_addr,
  input  logic [DATA_W-1:0]           ex_wdata,
  output logic                        ex_gnt,
  output logic                        ex_rvalid,
  output logic [DATA_W-1:0]           ex_rdata,
  input  logic                        accel_req,
  input  logic [ADDR_W-1:0]           accel_addr,
  input  logic [DATA_W-1:0]           accel_wdata,
  output logic                        accel_gnt,
  input  logic                        accel_burst_req,
  input  logic [ADDR_W-1:0]           accel_burst_addr,
  output logic                        accel_burst_ack,
  output logic                        accel_burst_err,
  output logic [BURST_LEN*DATA_W-1:0] accel_line,
  output logic                        accel_line_valid,
  output logic                        mem_en,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);
  import cpu_mem_arb_pkg::*;

  localparam int CW = $clog2(BURST_LEN) + 1;

  state_e state, state_nx;
  owner_e own, tag, tag_nx;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] beat_cnt, ret_cnt;
  logic [BURST_LEN-1:0][DATA_W-1:0] line_q;
  logic aligned, burst_start, ret_burst, last_ret, rr_en, rr_ex, rr_acc;

  assign aligned     = (accel_burst_addr & ADDR_W'(BURST_LEN-1)) == '0;
  assign burst_start = !rst && state == ST_IDLE && accel_burst_req && aligned;
  assign ret_burst   = tag == OWN_BURST;
  assign last_ret    = ret_burst && ret_cnt == CW'(BURST_LEN-1);
  // A burst acceptance claims the cycle ahead of the single-beat ports.
  assign rr_en       = !rst && state == ST_IDLE && !burst_start && !cpu_req;

  cpu_mem_rr2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (rr_en),
    .req_a (ex_req),
    .req_b (accel_req),
    .gnt_a (rr_ex),
    .gnt_b (rr_acc)
  );

  always_comb begin
    own = OWN_NONE;
    if (!rst) begin
      if (cpu_req)                                              own = OWN_CPU;
      else if (state == ST_BURST && beat_cnt < CW'(BURST_LEN))  own = OWN_BURST;
      else if (rr_ex)                                           own = OWN_EX;
      else if (rr_acc)                                          own = OWN_ACCEL;
    end
  end

  always_comb begin
    mem_en    = 1'b1;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_nx    = OWN_NONE;
    case (own)
      OWN_CPU: begin
        mem_wr = cpu_wr; mem_addr = cpu_addr; mem_wdata = cpu_wdata;
        if (!cpu_wr) tag_nx = OWN_CPU;
      end
      OWN_EX: begin
        mem_wr = ex_wr; mem_addr = ex_addr; mem_wdata = ex_wdata;
        if (!ex_wr) tag_nx = OWN_EX;
      end
      OWN_ACCEL: begin
        mem_wr = 1'b1; mem_addr = accel_addr; mem_wdata = accel_wdata;
      end
      OWN_BURST: begin
        mem_addr = base + ADDR_W'(beat_cnt);
        tag_nx   = OWN_BURST;
      end
      default: mem_en = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (burst_start) state_nx = ST_BURST;
      ST_BURST: if (last_ret)    state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tag      <= OWN_NONE;
      base     <= '0;
      beat_cnt <= '0;
      ret_cnt  <= '0;
      line_q   <= '0;
    end else begin
      state <= state_nx;
      tag   <= tag_nx;
      if (burst_start) begin
        base     <= accel_burst_addr;
        beat_cnt <= '0;
        ret_cnt  <= '0;
      end else begin
        if (own == OWN_BURST) beat_cnt <= beat_cnt + 1'b1;
        if (ret_burst) begin
          line_q[ret_cnt[CW-2:0]] <= mem_rdata;
          ret_cnt                 <= ret_cnt + 1'b1;
        end
      end
    end
  end

  assign cpu_gnt          = own == OWN_CPU;
  assign ex_gnt           = own == OWN_EX;
  assign accel_gnt        = own == OWN_ACCEL;
  assign cpu_rvalid       = !rst && tag == OWN_CPU;
  assign ex_rvalid        = !rst && tag == OWN_EX;
  assign cpu_rdata        = mem_rdata;
  assign ex_rdata         = mem_rdata;
  assign accel_burst_ack  = burst_start;
  assign accel_burst_err  = !rst && state == ST_IDLE && accel_burst_req && !aligned;
  assign accel_line_valid = !rst && last_ret;

  // The returning word is forwarded so the line is complete while line_valid is high.
  for (genvar k = 0; k < BURST_LEN; k++) begin : g_line
    assign accel_line[k*DATA_W +: DATA_W] =
      rst ? '0 : (ret_burst && ret_cnt == CW'(k)) ? mem_rdata : line_q[k];
  end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a shadow memory.
module tb_cpu_mem_arbiter;
  localparam int AW = 16, DW = 32, BL = 16;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic ex_req, ex_wr, ex_gnt, ex_rvalid;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata, ex_rdata;
  logic accel_req, accel_gnt;
  logic [AW-1:0] accel_addr;
  logic [DW-1:0] accel_wdata;
  logic accel_burst_req, accel_burst_ack, accel_burst_err, accel_line_valid;
  logic [AW-1:0] accel_burst_addr;
  logic [BL*DW-1:0] accel_line;
  logic mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ex_req(ex_req), .ex_wr(ex_wr), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_gnt(ex_gnt), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
    .accel_req(accel_req), .accel_addr(accel_addr), .accel_wdata(accel_wdata),
    .accel_gnt(accel_gnt),
    .accel_burst_req(accel_burst_req), .accel_burst_addr(accel_burst_addr),
    .accel_burst_ack(accel_burst_ack), .accel_burst_err(accel_burst_err),
    .accel_line(accel_line), .accel_line_valid(accel_line_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [9:0] a);
    if (a == 10'h020) return 32'hDEADBEEF;
    if (a >= 10'h100 && a < 10'h110) return 32'(a - 10'h100);
    return {6'h0, ~a, 6'h0, a};
  endfunction

  // Memory: 1-cycle read latency, unwritten words hold init_val.
  logic [DW-1:0] mem [0:1023];
  logic [1023:0] mem_wm = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem_wm[mem_addr[9:0]] ? mem[mem_addr[9:0]] : init_val(mem_addr[9:0]);
      if (mem_wr) begin
        mem[mem_addr[9:0]]    <= mem_wdata;
        mem_wm[mem_addr[9:0]] <= 1'b1;
      end
    end
  end

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] sh [0:1023];
  logic [1023:0] sh_wm = '0;
  logic          m_burst, m_host;
  logic [AW-1:0] m_base;
  int            m_iss, m_ret, p_who, p_k;
  logic [DW-1:0] p_data;
  logic [DW-1:0] m_line [BL];

  function automatic logic [BL*DW-1:0] pack_line();
    logic [BL*DW-1:0] r;
    for (int k = 0; k < BL; k++) r[k*DW +: DW] = m_line[k];
    return r;
  endfunction

  logic [2:0] obs_gnt;
  logic [1:0] obs_ae;
  logic obs_lv, obs_men, obs_exrv, obs_any;
  logic [DW-1:0] obs_exrd;
  logic [BL*DW-1:0] obs_line;

  task automatic model();
    logic e_ack, e_err, e_beat, e_ex, e_ac, e_lv, free, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int who;
    if (rst) begin
      chk("rst_outs", 512'(obs_any), 512'(0));
      chk("rst_line", obs_line, '0);
      m_burst = 0; m_host = 1; m_iss = 0; m_ret = 0; p_who = 0;
      for (int k = 0; k < BL; k++) m_line[k] = '0;
      return;
    end
    chk("rvalid", 512'({cpu_rvalid, ex_rvalid}), 512'({p_who == 1, p_who == 2}));
    if (p_who == 1) chk("cpu_rdata", 512'(cpu_rdata), 512'(p_data));
    if (p_who == 2) chk("ex_rdata", 512'(ex_rdata), 512'(p_data));
    e_lv = 0;
    if (p_who == 3) begin
      m_line[p_k] = p_data;
      m_ret++;
      e_lv = (m_ret == BL);
    end
    chk("line_valid", 512'(accel_line_valid), 512'(e_lv));
    if (e_lv) chk("line", accel_line, pack_line());

    e_ack  = !m_burst && accel_burst_req && (int'(accel_burst_addr) % BL == 0);
    e_err  = !m_burst && accel_burst_req && (int'(accel_burst_addr) % BL != 0);
    e_beat = m_burst && !cpu_req && m_iss < BL;
    free   = !m_burst && !e_ack && !cpu_req;
    e_ex   = free && ex_req && (!accel_req || m_host);
    e_ac   = free && accel_req && !e_ex;
    chk("grants", 512'({cpu_gnt, ex_gnt, accel_gnt, accel_burst_ack, accel_burst_err}),
        512'({cpu_req, e_ex, e_ac, e_ack, e_err}));

    who = 0; wr = 0; a = '0; wd = '0;
    if (cpu_req)     begin who = 1; wr = cpu_wr; a = cpu_addr; wd = cpu_wdata; end
    else if (e_beat) begin who = 3; a = m_base + AW'(m_iss); end
    else if (e_ex)   begin who = 2; wr = ex_wr; a = ex_addr; wd = ex_wdata; end
    else if (e_ac)   begin who = 4; wr = 1; a = accel_addr; wd = accel_wdata; end
    chk("mem_en", 512'(mem_en), 512'(who != 0));
    if (who == 3) chk("beat_acc", 512'({mem_wr, mem_addr}), 512'({1'b0, a}));
    else if (who != 0) chk("mem_acc", 512'({mem_wr, mem_addr, mem_wdata}), 512'({wr, a, wd}));

    p_who = 0;
    if (who != 0 && wr) begin
      sh[a[9:0]] = wd; sh_wm[a[9:0]] = 1'b1;
    end else if (who != 0) begin
      p_who  = who;
      p_data = sh_wm[a[9:0]] ? sh[a[9:0]] : init_val(a[9:0]);
      p_k    = m_iss;
    end
    if (who == 3) m_iss++;
    if (e_ex) m_host = 0;
    if (e_ac) m_host = 1;
    if (e_lv) m_burst = 0;
    if (e_ack) begin m_burst = 1; m_base = accel_burst_addr; m_iss = 0; m_ret = 0; end
  endtask

  task automatic cyc();
    @(negedge clk);
    obs_gnt  = {cpu_gnt, ex_gnt, accel_gnt};
    obs_ae   = {accel_burst_ack, accel_burst_err};
    obs_lv   = accel_line_valid;
    obs_men  = mem_en;
    obs_exrv = ex_rvalid;
    obs_exrd = ex_rdata;
    obs_line = accel_line;
    obs_any  = |{cpu_gnt, ex_gnt, accel_gnt, cpu_rvalid, ex_rvalid, accel_burst_ack,
                 accel_burst_err, accel_line_valid, mem_en};
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lv(output int n);
    n = 0;
    do begin cyc(); n++; end while (!obs_lv && n < 100);
  endtask

  int n, lvs;
  logic [BL*DW-1:0] ramp;

  initial begin
    for (int k = 0; k < BL; k++) ramp[k*DW +: DW] = DW'(k);
    rst = 1;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    ex_req = 0; ex_wr = 0; ex_addr = '0; ex_wdata = '0;
    accel_req = 0; accel_addr = '0; accel_wdata = '0;
    accel_burst_req = 0; accel_burst_addr = '0;
    cyc(); cyc();
    rst = 0;
    cyc();

    // Priority: CPU, then host, then accel
    cpu_req = 1; cpu_addr = 16'h0010;
    ex_req = 1; ex_addr = 16'h0020;
    accel_req = 1; accel_addr = 16'h0030; accel_wdata = 32'h12345678;
    cyc(); chk("prio_cpu", 512'(obs_gnt), 512'(3'b100));
    cpu_req = 0;
    cyc(); chk("prio_ex", 512'(obs_gnt), 512'(3'b010));
    ex_req = 0;
    cyc(); chk("prio_acc", 512'(obs_gnt), 512'(3'b001));
    chk("ex_rvalid", 512'(obs_exrv), 512'(1));
    chk("ex_rdata", 512'(obs_exrd), 512'(32'hDEADBEEF));
    accel_req = 0;
    cyc();

    // Aligned burst, no contention
    accel_burst_req = 1; accel_burst_addr = 16'h0100;
    cyc(); chk("ack", 512'(obs_ae), 512'(2'b10));
    accel_burst_req = 0;
    wait_lv(n);
    chk("burst_lat", 512'(n), 512'(17));
    chk("burst_line", obs_line, ramp);
    cyc(); chk("line_hold", obs_line, ramp);

    // Burst with CPU preempting every other cycle
    accel_burst_req = 1;
    cyc();
    accel_burst_req = 0;
    n = 0;
    do begin
      cpu_req = (n % 2 == 0); cpu_wr = 0; cpu_addr = AW'(n);
      cyc(); n++;
    end while (!obs_lv && n < 200);
    cpu_req = 0;
    chk("burst_cpu_lat", 512'(n), 512'(33));
    chk("burst_cpu_line", obs_line, ramp);

    // Misaligned burst, then prove the arbiter is still idle
    accel_burst_req = 1; accel_burst_addr = 16'h0105;
    cyc();
    chk("err", 512'(obs_ae), 512'(2'b01));
    chk("err_mem_en", 512'(obs_men), 512'(0));
    accel_burst_req = 0; ex_req = 1; ex_wr = 0; ex_addr = 16'h0021;
    cyc(); chk("err_idle", 512'(obs_gnt), 512'(3'b010));
    ex_req = 0;
    cyc();

    // Reset during beat 7
    accel_burst_req = 1; accel_burst_addr = 16'h0110;
    cyc();
    accel_burst_req = 0;
    repeat (7) cyc();
    rst = 1;
    cyc();
    chk("midrst_outs", 512'(obs_any), 512'(0));
    chk("midrst_line", obs_line, '0);
    rst = 0;
    lvs = 0;
    repeat (20) begin cyc(); if (obs_lv) lvs++; end
    chk("midrst_nolv", 512'(lvs), 512'(0));
    accel_burst_req = 1; accel_burst_addr = 16'h0100;
    cyc();
    accel_burst_req = 0;
    wait_lv(n);
    chk("reburst_lat", 512'(n), 512'(17));
    chk("reburst_line", obs_line, ramp);

    // Random traffic; requesters hold until granted
    repeat (3000) begin
      if (!cpu_req || obs_gnt[2]) begin
        cpu_req = $urandom_range(0, 3) == 0; cpu_wr = 1'($urandom);
        cpu_addr = AW'($urandom_range(0, 63)); cpu_wdata = $urandom;
      end
      if (!ex_req || obs_gnt[1]) begin
        ex_req = $urandom_range(0, 2) == 0; ex_wr = 1'($urandom);
        ex_addr = AW'($urandom_range(0, 63)); ex_wdata = $urandom;
      end
      if (!accel_req || obs_gnt[0]) begin
        accel_req = $urandom_range(0, 2) == 0;
        accel_addr = AW'($urandom_range(0, 63)); accel_wdata = $urandom;
      end
      accel_burst_req = $urandom_range(0, 19) == 0;
      accel_burst_addr = ($urandom_range(0, 3) == 0) ? AW'(16'h0100 + $urandom_range(1, 15))
                                                     : AW'(16'h0100 + 16 * $urandom_range(0, 3));
      rst = $urandom_range(0, 299) == 0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
